// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
//   Frequency-sweep (chirp) controller feeding the CORDIC NCO. It steps the
//   phase increment linearly from f_start to f_stop and holds each frequency
//   for dwell+1 cycles. Sweeps run once (single) or repeat (continuous).
//
//   Build option:
//     NCO_SWEEP_TRIANGLE_EN - when defined, the sweep turns at f_stop and runs
//                             back to f_start (triangle). When undefined, the
//                             sweep is a sawtooth that jumps back to f_start.
//
//   Ports:
//     clk_i        clock
//     rst_i        asynchronous, active-high reset
//     start_i      start pulse, sampled only while idle
//     stop_i       abort; takes priority over start_i
//     cont_i       1 = continuous, 0 = single sweep (latched at start)
//     f_start_i    start phase increment (latched at start)
//     f_stop_i     stop phase increment (latched at start)
//     f_step_i     unsigned step magnitude (latched at start)
//     dwell_i      extra cycles per frequency (latched at start)
//     phase_inc_o  phase increment to NCO
//     val_o        NCO valid/advance strobe
//     busy_o       sweep in progress
//     done_o       one-cycle pulse at the natural end of a single sweep
module nco_sweep_ctrl #(
  parameter int P_INC_W = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               cont_i,
  input  logic [P_INC_W-1:0] f_start_i,
  input  logic [P_INC_W-1:0] f_stop_i,
  input  logic [P_INC_W-1:0] f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [P_INC_W-1:0] phase_inc_o,
  output logic               val_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic               r_arm;       // config latched, first frequency due next edge
  logic               r_cont;
  logic               r_dir_up;
  logic [P_INC_W-1:0] r_f_start;
  logic [P_INC_W-1:0] r_f_stop;
  logic [P_INC_W-1:0] r_f_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [P_INC_W-1:0] r_phase_inc;
  logic               r_val;
  logic               r_busy;
  logic               r_done;

  logic               w_end;       // sweep end reached at this dwell expiry
  logic [P_INC_W-1:0] w_nxt;       // next frequency when not ending
  logic [P_INC_W-1:0] w_wrap;      // frequency to restart at in continuous mode

  // One saturating step from cur toward tgt; differences are unsigned so the
  // target is never overshot and the word never wraps.
  function automatic logic [P_INC_W-1:0] f_step_to(
    input logic [P_INC_W-1:0] cur,
    input logic [P_INC_W-1:0] tgt,
    input logic [P_INC_W-1:0] stp,
    input logic               up
  );
    logic [P_INC_W-1:0] d;
    d = up ? (tgt - cur) : (cur - tgt);
    if (d < stp) return tgt;
    return up ? (cur + stp) : (cur - stp);
  endfunction

`ifdef NCO_SWEEP_TRIANGLE_EN
  logic               r_leg;       // 0: heading to f_stop, 1: heading back to f_start
  logic               w_leg_nxt;

  always_comb begin
    w_end     = 1'b0;
    w_leg_nxt = r_leg;
    w_wrap    = r_f_start;
    w_nxt     = f_step_to(r_phase_inc, r_leg ? r_f_start : r_f_stop, r_f_step,
                          r_dir_up ^ r_leg);
    if (r_f_step == '0 || r_f_start == r_f_stop) begin
      // Nothing to sweep: a single dwell period at f_start.
      w_end = 1'b1;
    end else if (!r_leg && r_phase_inc == r_f_stop) begin
      // Turn at f_stop without repeating it.
      w_leg_nxt = 1'b1;
      w_nxt     = f_step_to(r_phase_inc, r_f_start, r_f_step, ~r_dir_up);
    end else if (r_leg && r_phase_inc == r_f_start) begin
      // Back at f_start: end, or turn again (continuous) without repeating it.
      w_end     = 1'b1;
      w_leg_nxt = 1'b0;
      w_wrap    = f_step_to(r_phase_inc, r_f_stop, r_f_step, r_dir_up);
    end
  end
`else
  always_comb begin
    w_wrap = r_f_start;
    w_nxt  = f_step_to(r_phase_inc, r_f_stop, r_f_step, r_dir_up);
    // A zero step can never reach f_stop, so it behaves as a single frequency.
    w_end  = (r_phase_inc == r_f_stop) || (r_f_step == '0);
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_arm       <= 1'b0;
      r_cont      <= 1'b0;
      r_dir_up    <= 1'b0;
      r_f_start   <= '0;
      r_f_stop    <= '0;
      r_f_step    <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_phase_inc <= '0;
      r_val       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
      r_leg       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_arm) begin
            r_arm <= 1'b0;
            if (!stop_i) begin
              r_state     <= S_RUN;
              r_phase_inc <= r_f_start;
              r_dwell_cnt <= r_dwell;
              r_val       <= 1'b1;
              r_busy      <= 1'b1;
            end
          end else if (start_i && !stop_i) begin
            r_arm     <= 1'b1;
            r_cont    <= cont_i;
            r_f_start <= f_start_i;
            r_f_stop  <= f_stop_i;
            r_f_step  <= f_step_i;
            r_dwell   <= dwell_i;
            r_dir_up  <= (f_stop_i >= f_start_i);
`ifdef NCO_SWEEP_TRIANGLE_EN
            r_leg     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (stop_i) begin
            r_state <= S_IDLE;
            r_val   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - 1'b1;
          end else begin
            r_dwell_cnt <= r_dwell;
            if (!w_end) begin
              r_phase_inc <= w_nxt;
`ifdef NCO_SWEEP_TRIANGLE_EN
              r_leg       <= w_leg_nxt;
`endif
            end else if (r_cont) begin
              r_phase_inc <= w_wrap;
`ifdef NCO_SWEEP_TRIANGLE_EN
              r_leg       <= w_leg_nxt;
`endif
            end else begin
              r_state <= S_IDLE;
              r_val   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign phase_inc_o = r_phase_inc;
  assign val_o       = r_val;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_nco_sweep_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stop_i, cont_i;
  logic [15:0] f_start_i, f_stop_i, f_step_i, dwell_i;
  logic [15:0] phase_inc_o;
  logic        val_o, busy_o, done_o;

  int n_chk  = 0;
  int n_pass = 0;

  nco_sweep_ctrl #(.P_INC_W(16), .DWELL_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .cont_i(cont_i), .f_start_i(f_start_i), .f_stop_i(f_stop_i),
    .f_step_i(f_step_i), .dwell_i(dwell_i), .phase_inc_o(phase_inc_o),
    .val_o(val_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // n cycles at frequency v with val high and no done pulse
  task automatic chk_run(input string tag, input int v, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_ph"}, 32'(phase_inc_o), v);
      chk({tag, "_val"}, 32'(val_o), 1);
      chk({tag, "_done0"}, 32'(done_o), 0);
      tick();
    end
  endtask

  // natural end of a single sweep: idle outputs with a one-cycle done pulse
  task automatic chk_end(input string tag, input int ph);
    chk({tag, "_end_val"}, 32'(val_o), 0);
    chk({tag, "_end_busy"}, 32'(busy_o), 0);
    chk({tag, "_end_done"}, 32'(done_o), 1);
    chk({tag, "_end_ph"}, 32'(phase_inc_o), ph);
    tick();
    chk({tag, "_done_clr"}, 32'(done_o), 0);
  endtask

  // issue a start pulse and advance to the first valid cycle
  task automatic go(input logic c, input int fs, input int fp, input int st, input int dw);
    cont_i = c; f_start_i = 16'(fs); f_stop_i = 16'(fp);
    f_step_i = 16'(st); dwell_i = 16'(dw);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; cont_i = 1'b0;
    f_start_i = '0; f_stop_i = '0; f_step_i = '0; dwell_i = '0;
    tick(); tick();
    chk("rst_ph", 32'(phase_inc_o), 0);
    chk("rst_val", 32'(val_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    rst_i = 1'b0;
    tick();

`ifndef NCO_SWEEP_TRIANGLE_EN
    // single up sweep, with the one-cycle start latency checked explicitly
    cont_i = 1'b0; f_start_i = 16'd100; f_stop_i = 16'd130;
    f_step_i = 16'd10; dwell_i = 16'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("up_lat_val", 32'(val_o), 0);
    tick();
    chk("up_busy", 32'(busy_o), 1);
    chk_run("up100", 100, 2);
    chk_run("up110", 110, 2);
    chk_run("up120", 120, 2);
    chk_run("up130", 130, 2);
    chk_end("up", 130);

    // saturating down sweep
    go(1'b0, 50, 20, 12, 0);
    chk_run("dn50", 50, 1);
    chk_run("dn38", 38, 1);
    chk_run("dn26", 26, 1);
    chk_run("dn20", 20, 1);
    chk_end("dn", 20);

    // continuous sawtooth, then abort
    go(1'b1, 0, 4, 2, 0);
    chk_run("ct0a", 0, 1);
    chk_run("ct2a", 2, 1);
    chk_run("ct4a", 4, 1);
    chk_run("ct0b", 0, 1);
    stop_i = 1'b1;
    chk_run("ct2b", 2, 1);
    stop_i = 1'b0;
    chk("ct_stop_val", 32'(val_o), 0);
    chk("ct_stop_busy", 32'(busy_o), 0);
    chk("ct_stop_done", 32'(done_o), 0);
    chk("ct_stop_ph", 32'(phase_inc_o), 2);
    tick();
    chk("ct_stop_done2", 32'(done_o), 0);

    // start during RUN is ignored and does not reload config
    go(1'b0, 100, 130, 10, 0);
    chk_run("ig100", 100, 1);
    start_i = 1'b1; f_start_i = 16'd500; f_stop_i = 16'd900; f_step_i = 16'd1;
    chk_run("ig110", 110, 1);
    start_i = 1'b0;
    chk_run("ig120", 120, 1);
    chk_run("ig130", 130, 1);
    chk_end("ig", 130);
`else
    // triangle single sweep
    go(1'b0, 0, 6, 3, 0);
    chk_run("tr0a", 0, 1);
    chk_run("tr3a", 3, 1);
    chk_run("tr6", 6, 1);
    chk_run("tr3b", 3, 1);
    chk_run("tr0b", 0, 1);
    chk_end("tr", 0);

    // continuous triangle turns at both ends without repeating them
    go(1'b1, 0, 4, 2, 0);
    chk_run("tc0a", 0, 1);
    chk_run("tc2a", 2, 1);
    chk_run("tc4", 4, 1);
    chk_run("tc2b", 2, 1);
    chk_run("tc0b", 0, 1);
    stop_i = 1'b1;
    chk_run("tc2c", 2, 1);
    stop_i = 1'b0;
    chk("tc_stop_val", 32'(val_o), 0);
    chk("tc_stop_done", 32'(done_o), 0);
    tick();
`endif

    // degenerate: start == stop
    go(1'b0, 7, 7, 5, 3);
    chk_run("eq7", 7, 4);
    chk_end("eq", 7);

    // degenerate: zero step
    go(1'b0, 5, 9, 0, 3);
    chk_run("z5", 5, 4);
    chk_end("z", 5);

    // start together with stop in IDLE: no sweep
    f_start_i = 16'd40; f_stop_i = 16'd60; f_step_i = 16'd5; dwell_i = 16'd0;
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    tick();
    chk("ss_val", 32'(val_o), 0);
    chk("ss_busy", 32'(busy_o), 0);
    chk("ss_ph", 32'(phase_inc_o), 5);

    // asynchronous reset mid-sweep
    go(1'b0, 200, 300, 10, 2);
    chk_run("ar200", 200, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_ph", 32'(phase_inc_o), 0);
    chk("ar_val", 32'(val_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_done", 32'(done_o), 0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("ar_idle_val", 32'(val_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
